// File: rtl/vga_pkg.sv
// vga_pkg: screen timing and geometry shared by the VGA buffer and display.
// Holds the 640x480@60 Hz horizontal/vertical timing, the placement of the
// doubled 256x192 source image inside the visible area, and the pass type
// used by the display when a source line is shown twice.
package vga_pkg;

  // Horizontal timing in screen pixels
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FRONT      = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BACK       = 10'd48;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [9:0] H_TOTAL      = H_SYNC_END + H_BACK;

  // Vertical timing in lines
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FRONT      = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BACK       = 10'd33;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic [9:0] V_TOTAL      = V_SYNC_END + V_BACK;

  // Source image size and its 2x-scaled placement on screen
  localparam int         SRC_WIDTH  = 256;
  localparam int         SRC_HEIGHT = 192;
  localparam logic [9:0] WIN_X0     = 10'd64;
  localparam logic [9:0] WIN_Y0     = 10'd48;
  localparam logic [9:0] WIN_X1     = WIN_X0 + 10'(2 * SRC_WIDTH);
  localparam logic [9:0] WIN_Y1     = WIN_Y0 + 10'(2 * SRC_HEIGHT);
  localparam int         LINE_AW    = $clog2(SRC_WIDTH);

  // Each source line is drawn twice: first while fetching from the buffer,
  // then replayed from the private line RAM.
  typedef enum logic {
    PASS_FETCH  = 1'b0,
    PASS_REPLAY = 1'b1
  } pass_e;

endpackage

// File: rtl/vga_line_ram.sv
// vga_line_ram: one source line (256 x 8) kept for the second screen line.
// Ports:
//   clk    - system clock
//   we     - write enable
//   waddr  - write address (source column)
//   wdata  - byte to store
//   raddr  - read address (source column)
//   rdata  - registered read data, valid the clk after raddr
module vga_line_ram
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [LINE_AW-1:0] waddr,
  input  logic [7:0]         wdata,
  input  logic [LINE_AW-1:0] raddr,
  output logic [7:0]         rdata
);

  logic [7:0] mem [SRC_WIDTH];

  // Plain block-RAM template: no reset, registered read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_display.sv
// vga_display: 640x480@60 Hz VGA timing with a 2x-scaled, centred 256x192
// source image and a black border.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   buf_rgb     - head byte of the VGA buffer
//   buf_empty   - buffer holds no valid byte
//   x_coord     - source column currently shown (0 outside the image)
//   y_coord     - source row currently shown (0 outside the image)
//   invalidate  - one-clk pop of the buffer head
//   vga_rgb     - RRRGGGBB pixel colour
//   vga_hsync   - horizontal sync, active low
//   vga_vsync   - vertical sync, active low
//   underflow   - sticky: buffer was empty when a byte was needed
// CLK_DIV clks make one screen pixel and must be at least 2.
module vga_display
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] buf_rgb,
  input  logic       buf_empty,
  output logic [7:0] x_coord,
  output logic [7:0] y_coord,
  output logic       invalidate,
  output logic [7:0] vga_rgb,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       underflow
);

  localparam int                DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             pix_en;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [8:0]       h_off;
  logic [8:0]       v_off;
  logic             in_win;
  logic [7:0]       src_x;
  logic [7:0]       src_y;
  logic             odd_px;
  pass_e            pass;
  logic             fetch_even;
  logic             fetch_odd;
  logic [7:0]       fetch_byte;
  logic [7:0]       ram_rdata;
  logic             pix_starved;

  // Pixel tick: counter value 0 is the tick clk, so the first clk after
  // reset release is already a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign pix_en = (div_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_TOTAL - 10'd1) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_TOTAL - 10'd1) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Window decode; offsets are only meaningful while in_win is set
  assign h_off      = 9'(h_cnt - WIN_X0);
  assign v_off      = 9'(v_cnt - WIN_Y0);
  assign in_win     = (h_cnt >= WIN_X0) && (h_cnt < WIN_X1) &&
                      (v_cnt >= WIN_Y0) && (v_cnt < WIN_Y1);
  assign src_x      = h_off[8:1];
  assign src_y      = v_off[8:1];
  assign odd_px     = h_off[0];
  assign pass       = pass_e'(v_off[0]);
  assign fetch_even = pix_en && in_win && (pass == PASS_FETCH) && !odd_px;
  assign fetch_odd  = pix_en && in_win && (pass == PASS_FETCH) && odd_px;
  assign fetch_byte = buf_empty ? 8'h00 : buf_rgb;

  // Between ticks h_cnt already holds the coordinate of the upcoming tick,
  // so reading at src_x lets the registered RAM output settle one clk
  // before that tick samples it (needs CLK_DIV >= 2).
  vga_line_ram u_line_ram (
    .clk   (clk),
    .we    (fetch_even),
    .waddr (src_x),
    .wdata (fetch_byte),
    .raddr (src_x),
    .rdata (ram_rdata)
  );

  // Monitor outputs, all updated together on the tick from the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_rgb   <= 8'h00;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      x_coord   <= 8'h00;
      y_coord   <= 8'h00;
    end else if (pix_en) begin
      vga_hsync <= !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
      vga_vsync <= !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
      if (!in_win) begin
        vga_rgb <= 8'h00;
        x_coord <= 8'h00;
        y_coord <= 8'h00;
      end else begin
        x_coord <= src_x;
        y_coord <= src_y;
        if (pass == PASS_REPLAY) begin
          vga_rgb <= ram_rdata;
        end else if (!odd_px) begin
          vga_rgb <= fetch_byte;
        end
      end
    end
  end

  // The pop is issued on the odd tick so the buffer has a full screen pixel
  // to present its next head; a starved pixel consumed nothing and must
  // not pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      invalidate  <= 1'b0;
      underflow   <= 1'b0;
      pix_starved <= 1'b0;
    end else begin
      invalidate <= fetch_odd && !pix_starved;
      if (fetch_even) begin
        pix_starved <= buf_empty;
        if (buf_empty) begin
          underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_display.sv
// tb_vga_display: drives vga_display with a modelled line buffer (byte =
// pop count mod 256) and compares every tick against a screen-level
// reference built from tick index -> (h, v) arithmetic.
module tb_vga_display;

  localparam int CLK_DIV     = 2;
  localparam int H_TOT       = 800;
  localparam int V_TOT       = 525;
  localparam int FRAME_TICKS = H_TOT * V_TOT;
  localparam int RESET_P     = (FRAME_TICKS + 60 * H_TOT + 300) * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] buf_rgb;
  logic       buf_empty;
  logic [7:0] x_coord;
  logic [7:0] y_coord;
  logic       invalidate;
  logic [7:0] vga_rgb;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       underflow;

  int checks;
  int fails;
  int p;
  int model_line [256];
  int exp_pops;
  int buf_count;
  bit cur_empty;
  bit pix_empty;
  bit exp_underflow;
  int inv_frame0;
  int inv_row0;
  int first_fall_t;
  int frame1_fall_t;
  bit hs_prev;

  vga_display #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .buf_rgb    (buf_rgb),
    .buf_empty  (buf_empty),
    .x_coord    (x_coord),
    .y_coord    (y_coord),
    .invalidate (invalidate),
    .vga_rgb    (vga_rgb),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (tick %0d)", tag, observed, expected, p / CLK_DIV);
      if (fails == 20) begin
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
      end
    end
  endtask

  // Chooses buf_empty for a source pixel just before its even-tick fetch
  task automatic applyStimulus(input bit fetch_even, input int frame, input int v, input int sx);
    if (fetch_even) begin
      if (frame == 1 && v == 48 && sx == 10) begin
        cur_empty = 1'b1;
      end else if (frame == 1 && v >= 50 && v < 60) begin
        cur_empty = ($urandom_range(7) == 0);
      end else begin
        cur_empty = 1'b0;
      end
      buf_empty = cur_empty;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rgb"}, int'(vga_rgb), 0);
    checkOutput({tag, "_hsync"}, int'(vga_hsync), 1);
    checkOutput({tag, "_vsync"}, int'(vga_vsync), 1);
    checkOutput({tag, "_inv"}, int'(invalidate), 0);
    checkOutput({tag, "_underflow"}, int'(underflow), 0);
    checkOutput({tag, "_x"}, int'(x_coord), 0);
    checkOutput({tag, "_y"}, int'(y_coord), 0);
  endtask

  task automatic runCycle();
    bit tick;
    int t, h, v, frame, sx, sy;
    bit win, replay, odd;
    int exp_inv, exp_rgb;
    tick   = (p % CLK_DIV) == 0;
    t      = p / CLK_DIV;
    frame  = t / FRAME_TICKS;
    h      = t % H_TOT;
    v      = (t / H_TOT) % V_TOT;
    win    = (h >= 64) && (h < 576) && (v >= 48) && (v < 432);
    sx     = win ? (h - 64) / 2 : 0;
    sy     = win ? (v - 48) / 2 : 0;
    replay = win && (((v - 48) % 2) == 1);
    odd    = win && (((h - 64) % 2) == 1);
    applyStimulus(tick && win && !replay && !odd, frame, v, sx);
    @(posedge clk);
    @(negedge clk);
    exp_inv = 0;
    if (tick && win && !replay) begin
      if (!odd) begin
        pix_empty = cur_empty;
        model_line[sx] = cur_empty ? 0 : exp_pops % 256;
        if (cur_empty) exp_underflow = 1'b1;
      end else if (!pix_empty) begin
        exp_inv = 1;
        exp_pops++;
      end
    end
    if (invalidate) begin
      buf_count++;
      buf_rgb = 8'(buf_count);
      if (frame == 0) inv_frame0++;
      if (frame == 1 && v == 48) inv_row0++;
    end
    checkOutput("invalidate", int'(invalidate), exp_inv);
    checkOutput("underflow", int'(underflow), int'(exp_underflow));
    if (tick) begin
      exp_rgb = win ? model_line[sx] : 0;
      checkOutput("rgb", int'(vga_rgb), exp_rgb);
      checkOutput("hsync", int'(vga_hsync), (h >= 656 && h < 752) ? 0 : 1);
      checkOutput("vsync", int'(vga_vsync), (v >= 490 && v < 492) ? 0 : 1);
      checkOutput("x_coord", int'(x_coord), sx);
      checkOutput("y_coord", int'(y_coord), sy);
      if (frame == 0 && v == 48 && (h == 64 || h == 65)) checkOutput("px_first", int'(vga_rgb), 0);
      if (frame == 0 && v == 48 && h == 66) checkOutput("px_second", int'(vga_rgb), 1);
      if (frame == 1 && (v == 48 || v == 49) && (h == 84 || h == 85))
        checkOutput("px_starved", int'(vga_rgb), 0);
      if (hs_prev && !vga_hsync) begin
        if (first_fall_t < 0) first_fall_t = t;
        if (t >= FRAME_TICKS && frame1_fall_t < 0) frame1_fall_t = t;
      end
      hs_prev = vga_hsync;
      if (t == 700) checkOutput("hsync_first_fall", first_fall_t, 656);
      if (t == FRAME_TICKS - 1) checkOutput("inv_per_frame", inv_frame0, 49152);
      if (frame == 1 && v == 48 && h == 799) checkOutput("row0_inv_count", inv_row0, 255);
      if (t == FRAME_TICKS + 700)
        checkOutput("frame_clks", (frame1_fall_t - first_fall_t) * CLK_DIV, 840000);
    end
    p++;
  endtask

  initial begin
    checks        = 0;
    fails         = 0;
    p             = 0;
    exp_pops      = 0;
    buf_count     = 0;
    cur_empty     = 1'b0;
    pix_empty     = 1'b0;
    exp_underflow = 1'b0;
    inv_frame0    = 0;
    inv_row0      = 0;
    first_fall_t  = -1;
    frame1_fall_t = -1;
    hs_prev       = 1'b1;
    for (int i = 0; i < 256; i++) model_line[i] = 0;
    rst_n     = 1'b1;
    buf_empty = 1'b0;
    buf_rgb   = 8'h00;
    #2 rst_n = 1'b0;
    #1 checkResetValues("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] running frame 0 and the start of frame 1");
    while (p <= RESET_P) runCycle();
    $display("[TB] reset asserted mid-line");
    rst_n = 1'b0;
    #1 checkResetValues("mid");
    exp_underflow = 1'b0;
    repeat (3) @(negedge clk);
    rst_n         = 1'b1;
    p             = 0;
    first_fall_t  = -1;
    frame1_fall_t = -1;
    hs_prev       = 1'b1;
    repeat (720 * CLK_DIV) runCycle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
